apb_decode_timeout: RTL
=======================

Name: apb_decode_timeout

Overview:
- Sits directly downstream of the MIC-to-APB bridge, between its single APB requester port and up to 2^NUM_CSEL_LOG2 APB completers.
- Decodes PSEL_BANK into per-peripheral selects and multiplexes PRDATA/PREADY back to the bridge.
- Guarantees every APB transfer completes: an absent bank, or a completer that stalls past TIMEOUT_CYCLES, gets an error response (ERR_DATA).
- Logs the first error since the last clear, plus a saturating error count, for software.

Parameters:
NUM_CSEL_LOG2, 3, bank select width; N = 2^NUM_CSEL_LOG2 completers
DECODE_BITS, 16, PADDR width (matches bridge)
TIMEOUT_CYCLES, 255, access-phase wait cycles before forced error completion (range 1..255)
PRESENT_MASK, 8'hff, N bits; bit b=1 means bank b is populated
ERR_DATA, 32'hdeadbeef, PRDATA returned on error completion

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
PSEL  in  1  from bridge
PSEL_BANK  in  NUM_CSEL_LOG2  from bridge
PENABLE  in  1  from bridge
PWRITE  in  1  from bridge
PADDR  in  DECODE_BITS  from bridge
PRDATA  out  32  to bridge
PREADY  out  1  to bridge
PSELX  out  N  per-completer select
PRDATA_IN  in  32*N  completer read data; bank b at [32b+31:32b]
PREADY_IN  in  N  completer ready
err_clr  in  1  clears error log
err_valid  out  1  sticky: error logged
err_bank  out  NUM_CSEL_LOG2  bank of first logged error
err_addr  out  DECODE_BITS  PADDR of first logged error
err_write  out  1  PWRITE of first logged error
err_timeout  out  1  1 = timeout, 0 = absent bank
err_count  out  8  saturating error count

Behaviour:
- Reset (async assert, sync deassert): state IDLE; cnt=0; err_valid=0, err_bank=0, err_addr=0, err_write=0, err_timeout=0, err_count=0.
- Outputs in reset: PSELX=0, PREADY=0, PRDATA=0.
- Decode: hit = PRESENT_MASK[PSEL_BANK]. PSELX[b] = PSEL & hit & (PSEL_BANK==b). Combinational, zero latency.
- States:
  - IDLE: PSEL=0.
  - SETUP: PSEL & !PENABLE.
  - ACCESS: PSEL & PENABLE, not yet complete.
  - Entry: IDLE->SETUP on PSEL. SETUP->ACCESS next cycle.
  - ACCESS->IDLE on completion when PSEL drops. Back-to-back transfers: SETUP again when PSEL stays high with PENABLE low.
  - PENABLE seen in IDLE (protocol error): treated as SETUP; no response.
- Access-phase counter cnt (8 bits):
  - Cleared outside ACCESS.
  - In ACCESS with selected PREADY_IN=0 and cnt<TIMEOUT_CYCLES: cnt increments.
- PREADY (combinational, asserted only when PSEL & PENABLE):
  - Absent bank: 1 in first access cycle.
  - Present bank: PREADY_IN[PSEL_BANK] | (cnt==TIMEOUT_CYCLES).
  - Otherwise 0.
- PRDATA:
  - ERR_DATA when absent, or timeout with PREADY_IN low.
  - Else PRDATA_IN[PSEL_BANK].
  - 0 when PSEL=0.
- Timeout: worst case completes on access cycle TIMEOUT_CYCLES+1. If PREADY_IN rises in the same cycle cnt reaches TIMEOUT_CYCLES, the real completer wins: real data, no error. After timeout, PSELX stays driven until the bridge drops PSEL (the bridge drops it on PREADY).
- Error event = completion cycle that is absent-bank or timeout.
  - On error event: err_count += 1, saturating at 255.
  - If err_valid=0: capture bank/addr/write/timeout and set err_valid. Later errors update err_count only.
- err_clr: clears err_valid and err_count next edge. Simultaneous err_clr and error event: error wins; log captures the new error and err_count=1.
- Writes: same decode and timeout rules; PRDATA ignored by the bridge.
- Reset mid-transfer: all state cleared immediately; outputs return to reset values.

Test Plan:
- Read bank 2 (present), PREADY_IN[2]=1 in first access cycle, PRDATA_IN bank2=32'h12345678 -> PSELX=8'h04 during SETUP/ACCESS, PREADY=1 in access cycle 1, PRDATA=32'h12345678, err_valid=0.
- PRESENT_MASK=8'h7f, read bank 7 -> PSELX=0, PREADY=1 in access cycle 1, PRDATA=32'hdeadbeef, err_valid=1, err_bank=7, err_timeout=0, err_count=1.
- TIMEOUT_CYCLES=4, bank 1 PREADY_IN held 0, write to PADDR=16'h0104 -> PREADY high exactly on access cycle 5, err_timeout=1, err_addr=16'h0104, err_write=1.
- TIMEOUT_CYCLES=4, PREADY_IN[1] rises on access cycle 5 with data 32'hcafef00d -> PRDATA=32'hcafef00d, no error logged.
- Two errors, then err_clr asserted on the same cycle as a third error -> err_count=1, err_* reflect the third error.
- reset_n pulsed low mid-access (async, between clk edges) -> PSELX=0, PREADY=0, err_count=0 immediately; next transfer completes normally.

Source files
------------

// File: rtl/apb_decode_timeout.sv
// -----------------------------------------------------------------------------
// apb_decode_timeout
//
// Purpose:
//   Sits between the MIC-to-APB bridge and up to 2^NUM_CSEL_LOG2 APB
//   completers. It decodes PSEL_BANK into per-completer selects and muxes
//   PRDATA/PREADY back to the bridge. Every transfer is guaranteed to finish:
//   an unpopulated bank completes at once with ERR_DATA, and a populated
//   completer that stalls for TIMEOUT_CYCLES access cycles is forced to
//   complete with ERR_DATA. The first error since the last clear is logged,
//   together with a saturating error count, for software.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   PSEL, PSEL_BANK,
//   PENABLE, PWRITE,
//   PADDR                 APB requester signals from the bridge
//   PRDATA, PREADY        response to the bridge
//   PSELX                 per-completer select, one bit per bank
//   PRDATA_IN, PREADY_IN  completer responses, bank b at PRDATA_IN[32b +: 32]
//   err_clr               clears err_valid and err_count
//   err_valid             sticky flag, an error has been logged
//   err_bank/addr/write   bank, PADDR and PWRITE of the first logged error
//   err_timeout           1 = first error was a timeout, 0 = absent bank
//   err_count             saturating count of error completions
// -----------------------------------------------------------------------------
module apb_decode_timeout #(
    parameter int                               NUM_CSEL_LOG2  = 3,
    parameter int                               DECODE_BITS    = 16,
    parameter int                               TIMEOUT_CYCLES = 255,
    parameter logic [(1<<NUM_CSEL_LOG2)-1:0]    PRESENT_MASK   = {(1<<NUM_CSEL_LOG2){1'b1}},
    parameter logic [31:0]                      ERR_DATA       = 32'hdeadbeef
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                PSEL,
    input  logic [NUM_CSEL_LOG2-1:0]            PSEL_BANK,
    input  logic                                PENABLE,
    input  logic                                PWRITE,
    input  logic [DECODE_BITS-1:0]              PADDR,
    output logic [31:0]                         PRDATA,
    output logic                                PREADY,
    output logic [(1<<NUM_CSEL_LOG2)-1:0]       PSELX,
    input  logic [32*(1<<NUM_CSEL_LOG2)-1:0]    PRDATA_IN,
    input  logic [(1<<NUM_CSEL_LOG2)-1:0]       PREADY_IN,
    input  logic                                err_clr,
    output logic                                err_valid,
    output logic [NUM_CSEL_LOG2-1:0]            err_bank,
    output logic [DECODE_BITS-1:0]              err_addr,
    output logic                                err_write,
    output logic                                err_timeout,
    output logic [7:0]                          err_count
);

    localparam int          N           = 1 << NUM_CSEL_LOG2;
    localparam logic [7:0]  TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    // state_q records the phase of the previous cycle. A completed access is
    // recorded as IDLE so that whatever follows it has to start with a setup.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                     state_q, state_d, curPhase;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       errValid_q, errValid_d;
    logic [NUM_CSEL_LOG2-1:0]   errBank_q, errBank_d;
    logic [DECODE_BITS-1:0]     errAddr_q, errAddr_d;
    logic                       errWrite_q, errWrite_d;
    logic                       errTimeout_q, errTimeout_d;
    logic [7:0]                 errCount_q, errCount_d;

    logic                       hit;
    logic                       inAccess;
    logic                       atLimit;
    logic                       timedOut;
    logic                       complete;
    logic                       errEvent;
    logic                       selReady;
    logic [31:0]                selData;

    // Mux the selected completer's ready and read data
    always_comb begin
        selData  = '0;
        selReady = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (PSEL_BANK == NUM_CSEL_LOG2'(b)) begin
                selData  = PRDATA_IN[32*b +: 32];
                selReady = PREADY_IN[b];
            end
        end
    end

    // Classify the current cycle. PENABLE without a preceding setup is a
    // protocol error and is handled as a setup, so it never gets a response.
    always_comb begin
        curPhase = IDLE;
        if (PSEL) begin
            if (PENABLE && (state_q == SETUP || state_q == ACCESS)) begin
                curPhase = ACCESS;
            end else begin
                curPhase = SETUP;
            end
        end
    end

    assign hit      = PRESENT_MASK[PSEL_BANK];
    assign inAccess = (curPhase == ACCESS);
    assign atLimit  = (cnt_q == TIMEOUT_VAL);
    // A completer that raises PREADY_IN on the limit cycle wins over the timeout
    assign timedOut = inAccess & hit & atLimit & ~selReady;
    assign complete = inAccess & (~hit | selReady | atLimit);
    assign errEvent = complete & (~hit | timedOut);

    // Responses are combinational; they are forced to idle values while in reset
    always_comb begin
        PSELX = '0;
        for (int b = 0; b < N; b++) begin
            PSELX[b] = reset_n & PSEL & hit & (PSEL_BANK == NUM_CSEL_LOG2'(b));
        end
        PREADY = reset_n & complete;
        PRDATA = '0;
        if (reset_n && PSEL) begin
            PRDATA = (~hit | timedOut) ? ERR_DATA : selData;
        end
    end

    // Next state. The counter only advances while an access is still waiting,
    // and waiting implies cnt_q < TIMEOUT_VAL, so it cannot pass the limit.
    // An error and err_clr on the same cycle behave as a clear followed by a
    // fresh first error.
    always_comb begin
        state_d      = complete ? IDLE : curPhase;
        cnt_d        = (inAccess && !complete) ? cnt_q + 8'd1 : 8'd0;
        errValid_d   = errValid_q;
        errBank_d    = errBank_q;
        errAddr_d    = errAddr_q;
        errWrite_d   = errWrite_q;
        errTimeout_d = errTimeout_q;
        errCount_d   = errCount_q;
        if (errEvent) begin
            if (err_clr) begin
                errCount_d = 8'd1;
            end else if (errCount_q != 8'hff) begin
                errCount_d = errCount_q + 8'd1;
            end
            if (!errValid_q || err_clr) begin
                errValid_d   = 1'b1;
                errBank_d    = PSEL_BANK;
                errAddr_d    = PADDR;
                errWrite_d   = PWRITE;
                errTimeout_d = hit;
            end
        end else if (err_clr) begin
            errValid_d = 1'b0;
            errCount_d = 8'd0;
        end
    end

    // Transfer FSM, access counter and error log registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            errValid_q   <= 1'b0;
            errBank_q    <= '0;
            errAddr_q    <= '0;
            errWrite_q   <= 1'b0;
            errTimeout_q <= 1'b0;
            errCount_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            errValid_q   <= errValid_d;
            errBank_q    <= errBank_d;
            errAddr_q    <= errAddr_d;
            errWrite_q   <= errWrite_d;
            errTimeout_q <= errTimeout_d;
            errCount_q   <= errCount_d;
        end
    end

    assign err_valid   = errValid_q;
    assign err_bank    = errBank_q;
    assign err_addr    = errAddr_q;
    assign err_write   = errWrite_q;
    assign err_timeout = errTimeout_q;
    assign err_count   = errCount_q;

endmodule
